mem_burst_ctrl: RTL and testbench



---
 rtl/mem_burst_ctrl_pkg.sv | 17 +
 rtl/mem_burst_ctrl.sv | 137 +++++++++++++
 tb/tb_mem_burst_ctrl.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_burst_ctrl_pkg.sv
// Shared types and default geometry for the SRAM burst controller.
// Widths match the 32K x 16 synchronous SRAM it drives.
package mem_burst_ctrl_pkg;

  localparam int DEFAULT_AW   = 15;
  localparam int DEFAULT_DW   = 16;
  localparam int DEFAULT_LENW = 4;
  localparam int MEM_DEPTH    = 2 ** DEFAULT_AW;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    TURN  = 2'd3
  } state_e;

endpackage

// File: rtl/mem_burst_ctrl.sv
// Turns a valid/ready request stream into single-word SRAM writes and 1..16 word
// pipelined read bursts; returns read words on a valid-only stream.
module mem_burst_ctrl
  import mem_burst_ctrl_pkg::*;
#(
  parameter int AW   = DEFAULT_AW,
  parameter int DW   = DEFAULT_DW,
  parameter int LENW = DEFAULT_LENW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [AW-1:0]   req_addr,
  input  logic [DW-1:0]   req_wdata,
  input  logic [LENW-1:0] req_len,
  output logic            rd_valid,
  output logic [DW-1:0]   rd_data,
  output logic            rd_last,
  output logic            busy,
  output logic [AW-1:0]   mem_addr,
  output logic            mem_oe,
  output logic            mem_we,
  inout  wire  [DW-1:0]   mem_data
);

  state_e          state_q, state_d;
  logic [LENW:0]   cnt_q, cnt_d;
  logic [LENW:0]   n_words;
  logic [LENW-1:0] len_q, len_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW-1:0]   rd_data_q, rd_data_d;
  logic            oe_q, oe_d;
  logic            we_q, we_d;
  logic            drv_q, drv_d;
  logic            rd_valid_q, rd_valid_d;
  logic            rd_last_q, rd_last_d;
  logic            busy_q, busy_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_data_d  = rd_data_q;
    oe_d       = 1'b0;
    we_d       = 1'b0;
    drv_d      = 1'b0;
    rd_valid_d = 1'b0;
    rd_last_d  = 1'b0;
    n_words    = {1'b0, len_q} + (LENW + 1)'(1);

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d = req_addr;
          cnt_d  = '0;
          if (req_we) begin
            state_d = WRITE;
            we_d    = 1'b1;
            drv_d   = 1'b1;
            wdata_d = req_wdata;
          end else begin
            state_d = READ;
            oe_d    = 1'b1;
            len_d   = req_len;
          end
        end
      end
      WRITE: state_d = IDLE;
      READ: begin
        // SRAM output is registered, so the word for address k-1 is on the bus in cycle k.
        if (cnt_q != '0) begin
          rd_valid_d = 1'b1;
          rd_data_d  = mem_data;
          rd_last_d  = (cnt_q == n_words);
        end
        if (cnt_q == n_words) begin
          state_d = TURN;
          cnt_d   = '0;
        end else begin
          oe_d  = 1'b1;
          cnt_d = cnt_q + (LENW + 1)'(1);
          if ((cnt_q + (LENW + 1)'(1)) < n_words) addr_d = addr_q + AW'(1);
        end
      end
      TURN: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      len_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_data_q  <= '0;
      oe_q       <= 1'b0;
      we_q       <= 1'b0;
      drv_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_data_q  <= rd_data_d;
      oe_q       <= oe_d;
      we_q       <= we_d;
      drv_q      <= drv_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      busy_q     <= busy_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign rd_last   = rd_last_q;
  assign busy      = busy_q;
  assign mem_addr  = addr_q;
  assign mem_oe    = oe_q;
  assign mem_we    = we_q;
  assign mem_data  = drv_q ? wdata_q : {DW{1'bz}};

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Directed bench for mem_burst_ctrl driving a behavioural 32K x 16 registered-read SRAM.
module tb_mem_burst_ctrl;
  import mem_burst_ctrl_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [14:0] req_addr;
  logic [15:0] req_wdata;
  logic [3:0]  req_len;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic        rd_last;
  logic        busy;
  logic [14:0] mem_addr;
  logic        mem_oe;
  logic        mem_we;
  wire  [15:0] mem_data;

  logic [15:0] sram_mem [0:MEM_DEPTH-1];
  logic [15:0] sram_q;
  logic        bd_we;
  logic [14:0] bd_addr;
  logic [15:0] bd_dat;

  int tests;
  int failed;

  mem_burst_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last), .busy(busy),
    .mem_addr(mem_addr), .mem_oe(mem_oe), .mem_we(mem_we), .mem_data(mem_data)
  );

  // SRAM load: registered read, output driven while oe is high; backdoor port for preload.
  always @(posedge clk) begin
    if (bd_we) sram_mem[bd_addr] <= bd_dat;
    else if (mem_we) sram_mem[mem_addr] <= mem_data;
    sram_q <= sram_mem[mem_addr];
  end
  assign mem_data = mem_oe ? sram_q : 16'hzzzz;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [14:0] a, input logic [15:0] d);
    bd_we = 1'b1; bd_addr = a; bd_dat = d;
    tick();
    bd_we = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    tests++; if (mem_oe !== 1'b0) begin failed++; $display("FAIL reset_oe got %b exp 0", mem_oe); end
    tests++; if (mem_we !== 1'b0) begin failed++; $display("FAIL reset_we got %b exp 0", mem_we); end
    tests++; if (mem_addr !== 15'h0) begin failed++; $display("FAIL reset_addr got %h exp 0", mem_addr); end
    tests++; if (rd_valid !== 1'b0) begin failed++; $display("FAIL reset_rd_valid got %b exp 0", rd_valid); end
    tests++; if (rd_last !== 1'b0) begin failed++; $display("FAIL reset_rd_last got %b exp 0", rd_last); end
    tests++; if (rd_data !== 16'h0) begin failed++; $display("FAIL reset_rd_data got %h exp 0", rd_data); end
    tests++; if (busy !== 1'b0) begin failed++; $display("FAIL reset_busy got %b exp 0", busy); end
    tests++; if (req_ready !== 1'b1) begin failed++; $display("FAIL reset_ready got %b exp 1", req_ready); end
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write();
    req_we = 1'b1; req_addr = 15'h0010; req_wdata = 16'hBEEF; req_len = 4'd0; req_valid = 1'b1;
    tests++; if (req_ready !== 1'b1) begin failed++; $display("FAIL wr_ready_before got %b exp 1", req_ready); end
    tick();
    req_valid = 1'b0;
    tests++; if (mem_we !== 1'b1) begin failed++; $display("FAIL wr_we got %b exp 1", mem_we); end
    tests++; if (mem_oe !== 1'b0) begin failed++; $display("FAIL wr_oe got %b exp 0", mem_oe); end
    tests++; if (mem_addr !== 15'h0010) begin failed++; $display("FAIL wr_addr got %h exp 0010", mem_addr); end
    tests++; if (mem_data !== 16'hBEEF) begin failed++; $display("FAIL wr_bus got %h exp BEEF", mem_data); end
    tests++; if (req_ready !== 1'b0) begin failed++; $display("FAIL wr_ready_during got %b exp 0", req_ready); end
    tests++; if (busy !== 1'b1) begin failed++; $display("FAIL wr_busy got %b exp 1", busy); end
    tick();
    tests++; if (req_ready !== 1'b1) begin failed++; $display("FAIL wr_ready_after got %b exp 1", req_ready); end
    tests++; if (mem_we !== 1'b0) begin failed++; $display("FAIL wr_we_after got %b exp 0", mem_we); end
    tests++; if (sram_mem[15'h0010] !== 16'hBEEF) begin failed++; $display("FAIL wr_mem got %h exp BEEF", sram_mem[15'h0010]); end
  endtask

  task automatic test_read_burst();
    logic [15:0] exp_w [4];
    exp_w = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    for (int i = 0; i < 4; i++) preload(15'h0020 + 15'(i), exp_w[i]);
    req_we = 1'b0; req_addr = 15'h0020; req_len = 4'd3; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) tick();
      if (c <= 4) begin
        tests++;
        if (mem_addr !== ((c < 4) ? 15'h0020 + 15'(c) : 15'h0023)) begin
          failed++; $display("FAIL rb_addr c=%0d got %h", c, mem_addr);
        end
      end
      tests++; if (mem_oe !== (c <= 4)) begin failed++; $display("FAIL rb_oe c=%0d got %b exp %b", c, mem_oe, c <= 4); end
      tests++; if (rd_valid !== (c >= 2 && c <= 5)) begin failed++; $display("FAIL rb_valid c=%0d got %b exp %b", c, rd_valid, c >= 2 && c <= 5); end
      if (c >= 2 && c <= 5) begin
        tests++; if (rd_data !== exp_w[c-2]) begin failed++; $display("FAIL rb_data c=%0d got %h exp %h", c, rd_data, exp_w[c-2]); end
        tests++; if (rd_last !== (c == 5)) begin failed++; $display("FAIL rb_last c=%0d got %b exp %b", c, rd_last, c == 5); end
      end
      if (c == 5) begin
        tests++; if (busy !== 1'b1 || req_ready !== 1'b0) begin failed++; $display("FAIL rb_turn busy=%b ready=%b exp 1/0", busy, req_ready); end
      end
      if (c == 6) begin
        tests++; if (busy !== 1'b0 || req_ready !== 1'b1) begin failed++; $display("FAIL rb_idle busy=%b ready=%b exp 0/1", busy, req_ready); end
      end
    end
  endtask

  task automatic test_wrap();
    logic [15:0] exp_w [3];
    logic [14:0] exp_a [4];
    exp_w = '{16'hA1A1, 16'hB2B2, 16'hC3C3};
    exp_a = '{15'h7FFE, 15'h7FFF, 15'h0000, 15'h0000};
    preload(15'h7FFE, exp_w[0]);
    preload(15'h7FFF, exp_w[1]);
    preload(15'h0000, exp_w[2]);
    req_we = 1'b0; req_addr = 15'h7FFE; req_len = 4'd2; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) tick();
      if (c <= 3) begin
        tests++; if (mem_addr !== exp_a[c]) begin failed++; $display("FAIL wrap_addr c=%0d got %h exp %h", c, mem_addr, exp_a[c]); end
      end
      tests++; if (rd_valid !== (c >= 2 && c <= 4)) begin failed++; $display("FAIL wrap_valid c=%0d got %b", c, rd_valid); end
      if (c >= 2 && c <= 4) begin
        tests++; if (rd_data !== exp_w[c-2]) begin failed++; $display("FAIL wrap_data c=%0d got %h exp %h", c, rd_data, exp_w[c-2]); end
      end
    end
  endtask

  task automatic test_read_then_write();
    preload(15'h0030, 16'h5A5A);
    req_we = 1'b0; req_addr = 15'h0030; req_len = 4'd0; req_valid = 1'b1;
    tick();
    req_we = 1'b1; req_addr = 15'h0031; req_wdata = 16'h1234;
    for (int c = 0; c < 7; c++) begin
      if (c > 0) tick();
      tests++; if (mem_oe === 1'b1 && mem_we === 1'b1) begin failed++; $display("FAIL rw_strobes c=%0d both oe and we high", c); end
      tests++; if (rd_valid !== (c == 2)) begin failed++; $display("FAIL rw_valid c=%0d got %b exp %b", c, rd_valid, c == 2); end
      if (c == 2) begin
        tests++; if (rd_data !== 16'h5A5A || rd_last !== 1'b1) begin failed++; $display("FAIL rw_word data=%h last=%b exp 5A5A/1", rd_data, rd_last); end
      end
      tests++; if (req_ready !== (c == 3 || c >= 5)) begin failed++; $display("FAIL rw_ready c=%0d got %b", c, req_ready); end
      tests++; if (mem_we !== (c == 4)) begin failed++; $display("FAIL rw_we c=%0d got %b exp %b", c, mem_we, c == 4); end
      if (c == 4) begin
        req_valid = 1'b0;
        tests++; if (mem_data !== 16'h1234 || mem_addr !== 15'h0031) begin failed++; $display("FAIL rw_bus data=%h addr=%h exp 1234/0031", mem_data, mem_addr); end
      end
      if (c == 5) begin
        tests++; if (sram_mem[15'h0031] !== 16'h1234) begin failed++; $display("FAIL rw_mem got %h exp 1234", sram_mem[15'h0031]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int nvalid;
    req_we = 1'b0; req_addr = 15'h0040; req_len = 4'd7; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick(); tick();
    tests++; if (rd_valid !== 1'b1) begin failed++; $display("FAIL rm_pre_valid got %b exp 1", rd_valid); end
    rst_n = 1'b0;
    #1;
    tests++; if (mem_oe !== 1'b0) begin failed++; $display("FAIL rm_oe got %b exp 0", mem_oe); end
    tests++; if (rd_valid !== 1'b0) begin failed++; $display("FAIL rm_valid got %b exp 0", rd_valid); end
    tests++; if (mem_we !== 1'b0 || busy !== 1'b0) begin failed++; $display("FAIL rm_we_busy we=%b busy=%b exp 0/0", mem_we, busy); end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    tests++; if (req_ready !== 1'b1) begin failed++; $display("FAIL rm_ready got %b exp 1", req_ready); end
    nvalid = 0;
    for (int c = 0; c < 12; c++) begin
      if (rd_valid === 1'b1 || mem_oe === 1'b1) nvalid++;
      tick();
    end
    tests++; if (nvalid != 0) begin failed++; $display("FAIL rm_after got %0d stray cycles exp 0", nvalid); end
  endtask

  task automatic test_back_to_back();
    int nvalid;
    req_we = 1'b1; req_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      req_addr = 15'h0100 + 15'(i); req_wdata = 16'(i + 1);
      tick();
      tests++; if (mem_we !== 1'b1 || mem_addr !== 15'h0100 + 15'(i) || mem_data !== 16'(i + 1)) begin
        failed++; $display("FAIL b2b_wr i=%0d we=%b addr=%h data=%h", i, mem_we, mem_addr, mem_data);
      end
      tick();
    end
    req_valid = 1'b0;
    req_we = 1'b0; req_addr = 15'h0100; req_len = 4'd15; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    nvalid = 0;
    for (int c = 0; c < 20; c++) begin
      if (c > 0) tick();
      if (rd_valid === 1'b1) nvalid++;
      tests++; if (rd_valid !== (c >= 2 && c <= 17)) begin failed++; $display("FAIL b2b_valid c=%0d got %b", c, rd_valid); end
      if (c >= 2 && c <= 17) begin
        tests++; if (rd_data !== 16'(c - 1)) begin failed++; $display("FAIL b2b_data c=%0d got %h exp %h", c, rd_data, 16'(c - 1)); end
        tests++; if (rd_last !== (c == 17)) begin failed++; $display("FAIL b2b_last c=%0d got %b", c, rd_last); end
      end
    end
    tests++; if (nvalid != 16) begin failed++; $display("FAIL b2b_count got %0d exp 16", nvalid); end
  endtask

  initial begin
    tests = 0; failed = 0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_len = '0;
    bd_we = 1'b0; bd_addr = '0; bd_dat = '0;
    test_reset();
    test_write();
    test_read_burst();
    test_wrap();
    test_read_then_write();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
